instr_encoder: RTL and testbench

//   Inverse of the instruction decode stage: takes field-level instruction requests, checks legality,

---
 rtl/isa_pkg.sv | 97 +++++++++
 rtl/enc_fifo.sv | 51 +++++
 rtl/instr_encoder.sv | 121 ++++++++++++
 tb/tb_instr_encoder.sv | 401 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Class-ISA encoding: class codes, opcodes, field positions, and the legality/packing helpers
// shared by the encoder datapath.
package isa_pkg;

  localparam int WORD_W = 32;

  localparam logic [1:0] CLS_DIMM = 2'b00;
  localparam logic [1:0] CLS_DREG = 2'b01;
  localparam logic [1:0] CLS_LDST = 2'b10;
  localparam logic [1:0] CLS_SYS  = 2'b11;

  localparam logic [4:0] OP_MOV   = 5'b00000;
  localparam logic [4:0] OP_MOVT  = 5'b00001;
  localparam logic [4:0] OP_NOT   = 5'b10110;
  localparam logic [4:0] OP_B     = 5'b00000;
  localparam logic [4:0] OP_BCOND = 5'b00001;
  localparam logic [4:0] OP_BR    = 5'b00010;
  localparam logic [4:0] OP_NOP   = 5'b00100;
  localparam logic [4:0] OP_HALT  = 5'b01000;

  localparam int CLS_LSB  = 30;
  localparam int OP_LSB   = 25;
  localparam int RD_LSB   = 22;
  localparam int COND_LSB = 21;
  localparam int RS1_LSB  = 19;
  localparam int RS2_LSB  = 16;
  localparam int IMM_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } enc_state_e;

  // ALU ops live at 10001-10101 and 11001-11101: op[4] set, op[2:0] in 1..5, op[3] selects S
  function automatic logic is_alu_op(input logic [4:0] op);
    return op[4] && (op[2:0] >= 3'd1) && (op[2:0] <= 3'd5);
  endfunction

  function automatic logic is_legal(input logic [1:0] cls, input logic [4:0] op);
    logic ok;
    case (cls)
      CLS_DIMM: ok = (op <= 5'd5) || is_alu_op(op);
      CLS_DREG: ok = is_alu_op(op) || (op == OP_NOT);
      CLS_LDST: ok = (op[4:1] == 4'd0);
      default:  ok = (op == OP_B) || (op == OP_BCOND) || (op == OP_BR) ||
                     (op == OP_NOP) || (op == OP_HALT);
    endcase
    return ok;
  endfunction

  function automatic logic [WORD_W-1:0] pack_word(
    input logic [1:0]  cls,
    input logic [4:0]  op,
    input logic [2:0]  rd,
    input logic [2:0]  rs1,
    input logic [2:0]  rs2,
    input logic [3:0]  cond,
    input logic [15:0] imm
  );
    logic [WORD_W-1:0] w;
    w = '0;
    w[CLS_LSB +: 2] = cls;
    w[OP_LSB +: 5]  = op;
    case (cls)
      CLS_DIMM: begin
        w[RD_LSB +: 3]   = rd;
        w[IMM_LSB +: 16] = imm;
        if ((op != OP_MOV) && (op != OP_MOVT)) w[RS1_LSB +: 3] = rs1;
      end
      CLS_DREG: begin
        w[RD_LSB +: 3]  = rd;
        w[RS1_LSB +: 3] = rs1;
        if (op != OP_NOT) w[RS2_LSB +: 3] = rs2;
      end
      CLS_LDST: begin
        w[RD_LSB +: 3]   = rd;
        w[RS1_LSB +: 3]  = rs1;
        w[IMM_LSB +: 16] = imm;
      end
      default: begin
        if (op == OP_B) begin
          w[IMM_LSB +: 16] = imm;
        end else if (op == OP_BCOND) begin
          w[COND_LSB +: 4] = cond;
          w[IMM_LSB +: 16] = imm;
        end else if (op == OP_BR) begin
          w[RS1_LSB +: 3]  = rs1;
          w[IMM_LSB +: 16] = imm;
        end
      end
    endcase
    return w;
  endfunction

endpackage

// File: rtl/enc_fifo.sv
// Word FIFO between the packer and instruction memory; flush empties it in one cycle.
// Push while full is honoured only when a pop happens in the same cycle.
module enc_fifo
  import isa_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = WORD_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  input  logic         i_pop,
  output logic [W-1:0] o_head,
  output logic         o_full,
  output logic         o_empty
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0]  r_wr_ptr;
  logic [PW:0]  r_rd_ptr;
  logic [W-1:0] r_mem [DEPTH];
  logic         w_do_push;
  logic         w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[PW] != r_rd_ptr[PW]) && (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_head    = r_mem[r_rd_ptr[PW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[PW-1:0]] <= i_data;
  end

endmodule

// File: rtl/instr_encoder.sv
// Field-level instruction requests in, legality-checked 32-bit words out to instruction memory.
// Holds the load/drain/done FSM, the packer and the write-address counter.
module instr_encoder
  import isa_pkg::*;
#(
  parameter int                DEPTH     = 4,
  parameter int                ADDR_W    = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ADDR_STEP = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              prog_end,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_cls,
  input  logic [4:0]        in_op,
  input  logic [2:0]        in_rd,
  input  logic [2:0]        in_rs1,
  input  logic [2:0]        in_rs2,
  input  logic [3:0]        in_cond,
  input  logic [15:0]       in_imm,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              enc_err,
  output logic [7:0]        err_cnt,
  output logic              done
);

  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

  enc_state_e        r_state;
  enc_state_e        w_state_nxt;
  logic              w_legal;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [31:0]       w_word;
  logic [31:0]       w_head;
  logic [ADDR_W-1:0] r_addr;
  logic              r_enc_err;
  logic [7:0]        r_err_cnt;

  assign w_legal  = is_legal(in_cls, in_op);
  assign w_word   = pack_word(in_cls, in_op, in_rd, in_rs1, in_rs2, in_cond, in_imm);
  // start flushes this cycle, so a request offered alongside it is dropped rather than half-loaded
  assign w_accept = in_valid & in_ready & ~start;
  assign w_push   = w_accept & w_legal;
  assign w_pop    = mem_we & mem_ready;

  enc_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (start),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    mem_we      = 1'b0;
    done        = 1'b0;
    case (r_state)
      ST_LOAD: begin
        in_ready = ~w_fifo_full;
        mem_we   = ~w_fifo_empty;
        if (prog_end) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        mem_we = ~w_fifo_empty;
        if (w_fifo_empty) w_state_nxt = ST_DONE;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
    if (start) w_state_nxt = ST_LOAD;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_addr <= BASE_ADDR;
    else if (start) r_addr <= BASE_ADDR;
    else if (w_pop) r_addr <= r_addr + STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_enc_err <= 1'b0;
      r_err_cnt <= '0;
    end else if (start) begin
      r_enc_err <= 1'b0;
      r_err_cnt <= '0;
    end else begin
      r_enc_err <= w_accept & ~w_legal;
      if (w_accept && !w_legal && (r_err_cnt != 8'hFF)) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign mem_addr  = r_addr;
  assign mem_wdata = mem_we ? w_head : 32'h0;
  assign enc_err   = r_enc_err;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed checks of instr_encoder against an arithmetic reference of the ISA rules.
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        prog_end = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_cls = '0;
  logic [4:0]  in_op = '0;
  logic [2:0]  in_rd = '0;
  logic [2:0]  in_rs1 = '0;
  logic [2:0]  in_rs2 = '0;
  logic [3:0]  in_cond = '0;
  logic [15:0] in_imm = '0;
  logic        mem_we;
  logic        mem_ready = 1'b0;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        enc_err;
  logic [7:0]  err_cnt;
  logic        done;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [47:0] got_q[$];
  logic [31:0] exp_q[$];
  int          exp_errs = 0;
  int          err_pulses = 0;

  instr_encoder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .prog_end(prog_end),
    .in_valid(in_valid), .in_ready(in_ready), .in_cls(in_cls), .in_op(in_op),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_cond(in_cond), .in_imm(in_imm),
    .mem_we(mem_we), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .enc_err(enc_err), .err_cnt(err_cnt), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_we && mem_ready) got_q.push_back({mem_addr, mem_wdata});
      if (enc_err) err_pulses++;
    end
  end

  localparam longint P16 = 65536, P19 = 524288, P21 = 2097152, P22 = 4194304;
  localparam longint P25 = 33554432, P30 = 1073741824;

  function automatic bit ref_legal(input logic [1:0] cls, input logic [4:0] op);
    case (cls)
      2'd0:    return (op <= 5'd5) || (op >= 5'd17 && op <= 5'd21) || (op >= 5'd25 && op <= 5'd29);
      2'd1:    return (op >= 5'd17 && op <= 5'd21) || (op >= 5'd25 && op <= 5'd29) || op == 5'd22;
      2'd2:    return op <= 5'd1;
      default: return op == 5'd0 || op == 5'd1 || op == 5'd2 || op == 5'd4 || op == 5'd8;
    endcase
  endfunction

  function automatic logic [31:0] ref_word(input logic [1:0] cls, input logic [4:0] op,
      input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
      input logic [3:0] cond, input logic [15:0] imm);
    longint w;
    w = longint'(cls) * P30 + longint'(op) * P25;
    case (cls)
      2'd0: begin
        w += longint'(rd) * P22 + longint'(imm);
        if (op > 5'd1) w += longint'(rs1) * P19;
      end
      2'd1: begin
        w += longint'(rd) * P22 + longint'(rs1) * P19;
        if (op != 5'd22) w += longint'(rs2) * P16;
      end
      2'd2: w += longint'(rd) * P22 + longint'(rs1) * P19 + longint'(imm);
      default: begin
        if (op == 5'd0)      w += longint'(imm);
        else if (op == 5'd1) w += longint'(cond) * P21 + longint'(imm);
        else if (op == 5'd2) w += longint'(rs1) * P19 + longint'(imm);
      end
    endcase
    return 32'(w);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_accept();
    if (ref_legal(in_cls, in_op))
      exp_q.push_back(ref_word(in_cls, in_op, in_rd, in_rs1, in_rs2, in_cond, in_imm));
    else
      exp_errs++;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    got_q.delete();
    exp_q.delete();
    exp_errs = 0;
    err_pulses = 0;
  endtask

  task automatic rand_req(input bit legal_only);
    in_cls  = 2'($urandom_range(0, 3));
    in_op   = 5'($urandom_range(0, 31));
    if (legal_only || $urandom_range(0, 3) != 0)
      for (int t = 0; t < 200 && !ref_legal(in_cls, in_op); t++) in_op = 5'($urandom_range(0, 31));
    in_rd   = 3'($urandom_range(0, 7));
    in_rs1  = 3'($urandom_range(0, 7));
    in_rs2  = 3'($urandom_range(0, 7));
    in_cond = 4'($urandom_range(0, 15));
    in_imm  = 16'($urandom_range(0, 65535));
  endtask

  task automatic send_cur();
    int b;
    in_valid = 1'b1;
    b = 0;
    @(negedge clk);
    while (!in_ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL send_timeout: in_ready=%b after %0d cycles, required 1", in_ready, b);
    end else begin
      model_accept();
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] c, input logic [4:0] o, input logic [2:0] rd,
      input logic [2:0] r1, input logic [2:0] r2, input logic [3:0] cd, input logic [15:0] im);
    in_cls = c; in_op = o; in_rd = rd; in_rs1 = r1; in_rs2 = r2; in_cond = cd; in_imm = im;
    send_cur();
  endtask

  task automatic wait_writes(input int n, input int budget);
    for (int b = 0; b < budget && got_q.size() < n; b++) tick();
  endtask

  task automatic test_reset();
    #2;
    n_checks += 7;
    if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    if (mem_we !== 1'b0)     begin n_fail++; $display("FAIL rst_mem_we got %b want 0", mem_we); end
    if (mem_addr !== 16'h0)  begin n_fail++; $display("FAIL rst_mem_addr got %h want 0000", mem_addr); end
    if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rst_mem_wdata got %h want 0", mem_wdata); end
    if (enc_err !== 1'b0)    begin n_fail++; $display("FAIL rst_enc_err got %b want 0", enc_err); end
    if (err_cnt !== 8'h0)    begin n_fail++; $display("FAIL rst_err_cnt got %0d want 0", err_cnt); end
    if (done !== 1'b0)       begin n_fail++; $display("FAIL rst_done got %b want 0", done); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL idle_in_ready got %b want 0", in_ready); end
  endtask

  task automatic test_directed();
    logic [47:0] want [4];
    want[0] = {16'h0000, 32'h00C01234};
    want[1] = {16'h0004, 32'h72530000};
    want[2] = {16'h0008, 32'hC3400010};
    want[3] = {16'h000C, 32'hD0000000};
    mem_ready = 1'b1;
    do_start();
    send(2'b00, 5'b00000, 3'd3, 3'd5, 3'd6, 4'hF, 16'h1234);
    n_checks++;
    if (mem_we !== 1'b1 || mem_wdata !== 32'h00C01234 || mem_addr !== 16'h0) begin
      n_fail++;
      $display("FAIL first_word_latency: we=%b data=%h addr=%h, want 1 00c01234 0000", mem_we, mem_wdata, mem_addr);
    end
    send(2'b01, 5'b11001, 3'd1, 3'd2, 3'd3, 4'h5, 16'hFFFF);
    send(2'b11, 5'b00001, 3'd7, 3'd7, 3'd7, 4'hA, 16'h0010);
    send(2'b11, 5'b01000, 3'd7, 3'd7, 3'd7, 4'hF, 16'hABCD);
    wait_writes(4, 50);
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (i >= got_q.size()) begin
        n_fail++; $display("FAIL directed_%0d: no write seen, want %h", i, want[i]);
      end else if (got_q[i] !== want[i]) begin
        n_fail++; $display("FAIL directed_%0d: got addr/data %h want %h", i, got_q[i], want[i]);
      end
    end
  endtask

  task automatic test_illegal();
    mem_ready = 1'b1;
    do_start();
    send(2'b01, 5'b00000, 3'd1, 3'd1, 3'd1, 4'h0, 16'h0);
    n_checks += 3;
    if (enc_err !== 1'b1) begin n_fail++; $display("FAIL illegal_pulse got %b want 1", enc_err); end
    if (err_cnt !== 8'd1) begin n_fail++; $display("FAIL illegal_cnt got %0d want 1", err_cnt); end
    if (mem_we !== 1'b0)  begin n_fail++; $display("FAIL illegal_we got %b want 0", mem_we); end
    tick();
    n_checks += 3;
    if (enc_err !== 1'b0)    begin n_fail++; $display("FAIL illegal_pulse_width got %b want 0", enc_err); end
    if (mem_addr !== 16'h0)  begin n_fail++; $display("FAIL illegal_addr got %h want 0000", mem_addr); end
    if (got_q.size() !== 0)  begin n_fail++; $display("FAIL illegal_writes got %0d want 0", got_q.size()); end
  endtask

  task automatic test_backpressure();
    int k;
    do_start();
    mem_ready = 1'b0;
    k = 0;
    rand_req(1'b1);
    for (int c = 0; c < 10; c++) begin
      in_valid = (k < 6);
      @(negedge clk);
      if (in_valid && in_ready) begin
        model_accept();
        k++;
      end
      if (mem_we) begin
        n_checks++;
        if (mem_addr !== 16'h0 || exp_q.size() == 0 || mem_wdata !== exp_q[0]) begin
          n_fail++;
          $display("FAIL stall_stable cycle %0d: addr=%h data=%h, want 0000 and first word", c, mem_addr, mem_wdata);
        end
      end
      @(posedge clk);
      #1;
      if (in_valid && k > 0 && exp_q.size() + exp_errs == k) rand_req(1'b1);
    end
    in_valid = 1'b0;
    n_checks++;
    if (k !== 4) begin n_fail++; $display("FAIL stall_accepts got %0d want 4", k); end
    mem_ready = 1'b1;
    for (int r = k; r < 6; r++) begin
      rand_req(1'b1);
      send_cur();
    end
    wait_writes(exp_q.size(), 60);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL stall_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== {16'(i * 4), exp_q[i]}) begin
        n_fail++; $display("FAIL stall_order_%0d got %h want %h", i, got_q[i], {16'(i * 4), exp_q[i]});
      end
    end
  endtask

  task automatic test_drain_done();
    do_start();
    mem_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      rand_req(1'b1);
      send_cur();
    end
    prog_end = 1'b1;
    tick();
    prog_end = 1'b0;
    n_checks += 3;
    if (done !== 1'b0)     begin n_fail++; $display("FAIL drain_done_early got %b want 0", done); end
    if (mem_we !== 1'b1)   begin n_fail++; $display("FAIL drain_we got %b want 1", mem_we); end
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL drain_in_ready got %b want 0", in_ready); end
    mem_ready = 1'b1;
    for (int b = 0; b < 50 && done !== 1'b1; b++) tick();
    n_checks += 3;
    if (done !== 1'b1)         begin n_fail++; $display("FAIL drain_done got %b want 1", done); end
    if (got_q.size() !== 3)    begin n_fail++; $display("FAIL drain_writes got %0d want 3", got_q.size()); end
    if (mem_addr !== 16'h000C) begin n_fail++; $display("FAIL drain_addr got %h want 000c", mem_addr); end
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== {16'(i * 4), exp_q[i]}) begin
        n_fail++; $display("FAIL drain_word_%0d got %h want %h", i, got_q[i], {16'(i * 4), exp_q[i]});
      end
    end
  endtask

  task automatic test_start_mid_drain();
    do_start();
    mem_ready = 1'b0;
    for (int r = 0; r < 3; r++) begin
      rand_req(1'b1);
      send_cur();
    end
    prog_end = 1'b1;
    tick();
    prog_end = 1'b0;
    do_start();
    n_checks += 4;
    if (mem_we !== 1'b0)    begin n_fail++; $display("FAIL restart_we got %b want 0", mem_we); end
    if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL restart_addr got %h want 0000", mem_addr); end
    if (done !== 1'b0)      begin n_fail++; $display("FAIL restart_done got %b want 0", done); end
    if (in_ready !== 1'b1)  begin n_fail++; $display("FAIL restart_in_ready got %b want 1", in_ready); end
    mem_ready = 1'b1;
    repeat (3) tick();
    n_checks++;
    if (got_q.size() !== 0) begin n_fail++; $display("FAIL restart_flush got %0d writes want 0", got_q.size()); end
  endtask

  task automatic test_random();
    int want_cnt;
    do_start();
    for (int c = 0; c < 120; c++) begin
      rand_req(1'b0);
      in_valid  = ($urandom_range(0, 3) != 0);
      mem_ready = ($urandom_range(0, 3) != 0);
      prog_end  = (c == 119);
      @(negedge clk);
      if (in_valid && in_ready) model_accept();
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    prog_end = 1'b0;
    mem_ready = 1'b1;
    for (int b = 0; b < 100 && done !== 1'b1; b++) tick();
    tick();
    want_cnt = (exp_errs > 255) ? 255 : exp_errs;
    n_checks += 5;
    if (done !== 1'b1)    begin n_fail++; $display("FAIL rand_done got %b want 1", done); end
    if (got_q.size() !== exp_q.size()) begin
      n_fail++; $display("FAIL rand_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    if (err_cnt !== 8'(want_cnt)) begin n_fail++; $display("FAIL rand_err_cnt got %0d want %0d", err_cnt, want_cnt); end
    if (err_pulses !== exp_errs)  begin n_fail++; $display("FAIL rand_err_pulses got %0d want %0d", err_pulses, exp_errs); end
    if (mem_we !== 1'b0)          begin n_fail++; $display("FAIL rand_done_we got %b want 0", mem_we); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== {16'(i * 4), exp_q[i]}) begin
        n_fail++; $display("FAIL rand_word_%0d got %h want %h", i, got_q[i], {16'(i * 4), exp_q[i]});
      end
    end
  endtask

  task automatic test_err_saturate();
    mem_ready = 1'b1;
    do_start();
    for (int i = 0; i < 260; i++) send(2'b10, 5'b11111, 3'd0, 3'd0, 3'd0, 4'h0, 16'h0);
    tick();
    n_checks++;
    if (err_cnt !== 8'd255) begin n_fail++; $display("FAIL err_saturate got %0d want 255", err_cnt); end
  endtask

  task automatic test_reset_mid();
    mem_ready = 1'b0;
    do_start();
    send(2'b10, 5'b00001, 3'd2, 3'd4, 3'd0, 4'h0, 16'h0040);
    send(2'b11, 5'b11111, 3'd0, 3'd0, 3'd0, 4'h0, 16'h0);
    #2;
    rst_n = 1'b0;
    #1;
    n_checks += 5;
    if (mem_we !== 1'b0)     begin n_fail++; $display("FAIL rstmid_we got %b want 0", mem_we); end
    if (mem_wdata !== 32'h0) begin n_fail++; $display("FAIL rstmid_wdata got %h want 0", mem_wdata); end
    if (err_cnt !== 8'd0)    begin n_fail++; $display("FAIL rstmid_err_cnt got %0d want 0", err_cnt); end
    if (in_ready !== 1'b0)   begin n_fail++; $display("FAIL rstmid_in_ready got %b want 0", in_ready); end
    if (mem_addr !== 16'h0)  begin n_fail++; $display("FAIL rstmid_addr got %h want 0000", mem_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_addr_wrap();
    mem_ready = 1'b1;
    do_start();
    for (int i = 0; i < 16385; i++) send(2'b11, 5'b00100, 3'd7, 3'd7, 3'd7, 4'hF, 16'hFFFF);
    wait_writes(16385, 50);
    n_checks += 3;
    if (got_q.size() !== 16385) begin
      n_fail++; $display("FAIL wrap_count got %0d want 16385", got_q.size());
    end else begin
      if (got_q[16383] !== {16'hFFFC, 32'hC8000000}) begin
        n_fail++; $display("FAIL wrap_last got %h want fffcc8000000", got_q[16383]);
      end
      if (got_q[16384] !== {16'h0000, exp_q[16384]}) begin
        n_fail++; $display("FAIL wrap_first got %h want 0000%h", got_q[16384], exp_q[16384]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_illegal();
    test_backpressure();
    test_drain_done();
    test_start_mid_drain();
    test_random();
    test_err_saturate();
    test_reset_mid();
    test_addr_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
